// File: rtl/gf8_pkg.sv
// Shared GF(2^8) definitions for the carry-less multiplier and the reduction stage downstream.
package gf8_pkg;

    localparam int GF_WIDTH = 8;
    // x^8+x^7+x^5+x^4+x^2+x+1, consumed by the reduction stage rather than by the multiplier
    localparam logic [8:0] GF_POLY = 9'h1B7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } gf_state_t;

    typedef logic [GF_WIDTH-1:0]   gf_elem_t;
    typedef logic [2*GF_WIDTH-1:0] gf_wide_t;

endpackage

// File: rtl/gf8_clmul_step.sv
// One shift-and-add step of the carry-less multiply: conditionally XOR the shifted multiplicand.
module gf8_clmul_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mcand,
    input  logic             b_lsb,
    output logic [WIDTH-1:0] acc_next
);

    assign acc_next = acc ^ (b_lsb ? mcand : '0);

endmodule

// File: rtl/gf8_clmul_seq.sv
// Iterative carry-less multiplier: one multiplier bit per cycle, unreduced 2*WIDTH-bit product.
module gf8_clmul_seq
    import gf8_pkg::*;
#(
    parameter int WIDTH = GF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 prod_valid,
    input  logic                 prod_ready,
    output logic [2*WIDTH-1:0]   prod_data
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]           state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]     breg;
    logic [CNT_W-1:0]     cnt;

    gf8_clmul_step #(
        .WIDTH (2*WIDTH)
    ) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .b_lsb    (breg[0]),
        .acc_next (acc_next)
    );

    // mcand is double width so WIDTH-1 left shifts never lose a coefficient
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            mcand <= '0;
            breg  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc   <= '0;
                        mcand <= {{WIDTH{1'b0}}, in_a};
                        breg  <= in_b;
                        cnt   <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc   <= acc_next;
                    mcand <= mcand << 1;
                    breg  <= breg >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (prod_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake outputs decode straight from the state register
    assign in_ready   = (state == ST_IDLE);
    assign prod_valid = (state == ST_DONE);
    assign prod_data  = acc;

endmodule
